// File: rtl/dpram_sc_ctrl.sv
// Single-clock true dual-port RAM with a post-reset clear engine and fixed same-address arbitration.
// Read latency is 1 cycle; there is no back-pressure, and requests are ignored until init_done.
module dpram_sc_ctrl #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_acc, b_acc, same_addr;
  logic a_wr, b_wr, a_rd, b_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    init_done = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = READY;
      end
      READY: begin
        init_done = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign a_acc     = a_en & init_done;
  assign b_acc     = b_en & init_done;
  assign same_addr = (a_addr == b_addr);
  assign a_wr      = a_acc & a_we;
  // Port A wins a write/write conflict; B's write is simply dropped.
  assign b_wr      = b_acc & b_we & ~(a_wr & same_addr);
  assign a_rd      = a_acc & ~a_we;
  assign b_rd      = b_acc & ~b_we;

  // The clear engine owns the array while in CLEAR; reset itself never touches contents.
  always_ff @(posedge clk) begin
    if (!rst && clr_we) begin
      mem[clr_ptr_q] <= '0;
    end else if (!rst) begin
      if (a_wr) mem[a_addr] <= a_din;
      if (b_wr) mem[b_addr] <= b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout    <= '0;
      b_dout    <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_valid   <= a_rd;
      b_valid   <= b_rd;
      collision <= a_acc & b_acc & same_addr & (a_we | b_we);
      if (a_rd) begin
        if (RDW_MODE != 0 && b_wr && same_addr) a_dout <= b_din;
        else                                    a_dout <= mem[a_addr];
      end
      if (b_rd) begin
        if (RDW_MODE != 0 && a_wr && same_addr) b_dout <= a_din;
        else                                    b_dout <= mem[b_addr];
      end
    end
  end

endmodule
